// File: rtl/jt12_pcm_uprate_if.sv
// PCM sample bus between the YM2612 register interface and the up-rate core.
// The register side drives pcm/pcm_wr and the core returns pcm_out/rate/stale.
interface jt12_pcm_uprate_if #(
    parameter int W      = 9,
    parameter int STAGES = 3
);
    localparam int RW = $clog2(STAGES + 1);

    logic signed [W-1:0] pcm;
    logic                pcm_wr;
    logic signed [W-1:0] pcm_out;
    logic [RW-1:0]       rate;
    logic                stale;

    modport master (output pcm, pcm_wr, input pcm_out, rate, stale);
    modport slave  (input pcm, pcm_wr, output pcm_out, rate, stale);
endinterface

// File: rtl/jt12_pcm_uprate.sv
// PCM up-rate core: picks a 2^k factor from the write interval and linearly interpolates per tick.
// Define JT12_PCM_DECAY_EN to make a stale output step one LSB toward zero on every tick.
module jt12_pcm_uprate #(
    parameter int W      = 9,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               zero,
    jt12_pcm_uprate_if.slave   bus
);
    localparam int RW  = $clog2(STAGES + 1);
    localparam int GW  = STAGES + 2;
    localparam int PW  = W + STAGES + 2;
    localparam int PHW = STAGES + 1;
    localparam logic [GW-1:0] GMAX = {1'b0, {(GW-1){1'b1}}};

    function automatic logic [RW-1:0] rate_of(input logic [GW-1:0] g);
        logic [RW-1:0] k;
        k = '0;
        for (int i = 1; i < GW; i++)
            if (g[i]) k = (i > STAGES) ? RW'(STAGES) : RW'(i);
        return k;
    endfunction

    // Arithmetic shift floors the scaled step; the result always lies between a and b.
    function automatic logic signed [W-1:0] interp(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b,
                                                   input logic [PHW-1:0]      ph_v,
                                                   input logic [RW-1:0]       k);
        logic signed [W:0]    d;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sh;
        d    = {b[W-1], b} - {a[W-1], a};
        prod = PW'(d) * $signed({1'b0, ph_v});
        sh   = prod >>> k;
        return a + W'(sh);
    endfunction

`ifdef JT12_PCM_DECAY_EN
    function automatic logic signed [W-1:0] decay(input logic signed [W-1:0] v);
        if (v > 0)      return v - W'(1);
        else if (v < 0) return v + W'(1);
        else            return v;
    endfunction
`endif

    logic                last_zero;
    logic [GW-1:0]       gap;
    logic signed [W-1:0] prev, curr, pcm_out_r;
    logic [PHW-1:0]      ph;
    logic [RW-1:0]       rate_r;
    logic                stale_r;

    logic                tick;
    logic [RW-1:0]       k_new;
    logic signed [W-1:0] seg_prev, seg_curr, interp_v;
    logic [RW-1:0]       seg_k;
    logic [PHW-1:0]      seg_ph, seg_full, ph_nxt;

    assign tick  = zero & ~last_zero;
    assign k_new = rate_of(gap);

    // A write re-bases the segment first so a coincident tick already steps the new one.
    always_comb begin
        seg_prev = prev;
        seg_curr = curr;
        seg_k    = rate_r;
        seg_ph   = ph;
        if (bus.pcm_wr) begin
            seg_prev = pcm_out_r;
            seg_curr = bus.pcm;
            seg_k    = k_new;
            seg_ph   = '0;
        end
        seg_full = PHW'(1) << seg_k;
        ph_nxt   = (seg_ph >= seg_full) ? seg_ph : seg_ph + 1'b1;
        interp_v = interp(seg_prev, seg_curr, ph_nxt, seg_k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_zero <= 1'b0;
            gap       <= '0;
            prev      <= '0;
            curr      <= '0;
            ph        <= '0;
            pcm_out_r <= '0;
            rate_r    <= '0;
            stale_r   <= 1'b0;
        end else if (clk_en) begin
            last_zero <= zero;
            if (bus.pcm_wr)
                gap <= '0;
            else if (tick && gap != GMAX)
                gap <= gap + 1'b1;
            if (bus.pcm_wr) begin
                prev   <= pcm_out_r;
                curr   <= bus.pcm;
                rate_r <= k_new;
            end
            if (bus.pcm_wr || tick)
                ph <= tick ? ph_nxt : '0;
            if (tick) begin
`ifdef JT12_PCM_DECAY_EN
                if (stale_r && !bus.pcm_wr)
                    pcm_out_r <= decay(pcm_out_r);
                else
                    pcm_out_r <= interp_v;
`else
                pcm_out_r <= interp_v;
`endif
            end
            if (bus.pcm_wr)
                stale_r <= 1'b0;
            else if (tick && gap == GMAX)
                stale_r <= 1'b1;
        end
    end

    assign bus.pcm_out = pcm_out_r;
    assign bus.rate    = rate_r;
    assign bus.stale   = stale_r;
endmodule

// File: tb/tb_jt12_pcm_uprate.sv
// Directed bench for jt12_pcm_uprate (W=9, STAGES=3): vector table plus reset, gating and stale sequences.
module tb_jt12_pcm_uprate;
    localparam int W = 9;
    localparam int STAGES = 3;
    localparam int OP_TK = 0;
    localparam int OP_WR = 1;
    localparam int OP_WT = 2;

    typedef struct {
        int op;
        int p;
        int eo;
        int er;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic zero = 1'b0;

    jt12_pcm_uprate_if #(.W(W), .STAGES(STAGES)) bus ();

    jt12_pcm_uprate #(.W(W), .STAGES(STAGES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .zero   (zero),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

`ifdef JT12_PCM_DECAY_EN
    int dexp[6] = '{4, 3, 2, 1, 0, 0};
    int out_after_decay = 0;
`else
    int dexp[6] = '{5, 5, 5, 5, 5, 5};
    int out_after_decay = 5;
`endif

    function automatic void add(input int op, input int p, input int eo, input int er);
        vec_t v;
        v.op = op; v.p = p; v.eo = eo; v.er = er;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int eo, input int er, input int es);
        chk({name, " pcm_out"}, int'($signed(bus.pcm_out)), eo);
        chk({name, " rate"}, int'(bus.rate), er);
        chk({name, " stale"}, int'(bus.stale), es);
    endtask

    task automatic step(input logic z, input logic w, input int p);
        zero = z;
        bus.pcm_wr = w;
        bus.pcm = W'(p);
        @(negedge clk);
    endtask

    task automatic do_op(input int op, input int p);
        case (op)
            OP_TK:   begin step(1'b1, 1'b0, 0); step(1'b0, 1'b0, 0); end
            OP_WR:   begin step(1'b0, 1'b1, p); step(1'b0, 1'b0, p); end
            default: begin step(1'b1, 1'b1, p); step(1'b0, 1'b0, p); end
        endcase
    endtask

    initial begin
        bus.pcm = '0;
        bus.pcm_wr = 1'b0;

        // x1 writes between ticks, then coincident with ticks
        add(OP_WR, 100, 0, 0);   add(OP_TK, 0, 100, 0);
        add(OP_WR, 101, 100, 0); add(OP_TK, 0, 101, 0);
        add(OP_WR, 102, 101, 0); add(OP_TK, 0, 102, 0);
        add(OP_WT, 100, 100, 0); add(OP_WT, 101, 101, 0); add(OP_WT, 102, 102, 0);
        // x8: 0 then 80 after 8 ticks
        add(OP_WR, 0, 102, 0);
        for (int i = 0; i < 8; i++) add(OP_TK, 0, 0, 0);
        add(OP_WR, 80, 0, 3);
        for (int i = 1; i <= 8; i++) add(OP_TK, 0, 10 * i, 3);
        add(OP_TK, 0, 80, 3);
        // negative x4
        add(OP_WR, 80, 80, 3);
        for (int i = 0; i < 4; i++) add(OP_TK, 0, 80, 3);
        add(OP_WR, -80, 80, 2);
        add(OP_TK, 0, 40, 2); add(OP_TK, 0, 0, 2); add(OP_TK, 0, -40, 2); add(OP_TK, 0, -80, 2);
        // x4 0->80 interrupted at ph=2 by an early write of 0
        add(OP_WR, 0, -80, 2);
        add(OP_TK, 0, -60, 2); add(OP_TK, 0, -40, 2); add(OP_TK, 0, -20, 2); add(OP_TK, 0, 0, 2);
        add(OP_WR, 80, 0, 2);
        add(OP_TK, 0, 20, 2); add(OP_TK, 0, 40, 2);
        add(OP_WR, 0, 40, 1);
        add(OP_TK, 0, 20, 1); add(OP_TK, 0, 0, 1); add(OP_TK, 0, 0, 1);

        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].p);
            chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].er, 0);
        end

        // Gated zero edges and writes must not move gap or outputs
        do_op(OP_WR, 50);
        chk_all("gate wr50", 0, 1, 0);
        do_op(OP_TK, 0);
        do_op(OP_TK, 0);
        chk_all("gate pre", 50, 1, 0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, -100);
            step(1'b0, 1'b0, 0);
        end
        chk_all("gate off", 50, 1, 0);
        clk_en = 1'b1;
        do_op(OP_WR, 10);
        chk_all("gate gap", 50, 1, 0);
        do_op(OP_TK, 0);
        chk_all("gate tick", 30, 1, 0);

        // Asynchronous reset mid-stream at pcm_out=50
        do_op(OP_TK, 0);
        do_op(OP_TK, 0);
        do_op(OP_WR, 50);
        do_op(OP_TK, 0);
        do_op(OP_TK, 0);
        chk_all("pre reset", 50, 1, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async reset", 0, 0, 0);
        zero = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        do_op(OP_TK, 0);
        do_op(OP_WR, 8);
        chk_all("release tick", 0, 1, 0);
        do_op(OP_TK, 0);
        chk_all("release seg", 4, 1, 0);

        // Stale detection and decay from pcm_out=5
        do_op(OP_WR, 5);
        do_op(OP_TK, 0);
        chk_all("stale start", 5, 0, 0);
        for (int i = 0; i < 14; i++) do_op(OP_TK, 0);
        chk_all("stale 14", 5, 0, 0);
        do_op(OP_TK, 0);
        chk_all("stale 15", 5, 0, 1);
        for (int i = 0; i < 6; i++) begin
            do_op(OP_TK, 0);
            chk_all($sformatf("decay%0d", i), dexp[i], 0, 1);
        end
        do_op(OP_WR, 20);
        chk_all("stale clear", out_after_decay, 3, 0);
        for (int i = 0; i < 16; i++) do_op(OP_TK, 0);
        chk_all("stale again", 20, 3, 1);
        #2 rst_n = 1'b0;
        #1 chk_all("reset stale", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        zero = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jt12_pcm_uprate.md
# jt12_pcm_uprate

Parametrised PCM sample-rate up-converter for the YM2612 DAC path. It measures the interval between CPU PCM writes in output-sample ticks, selects an up-rate factor of 2^k (k ≤ STAGES), and linearly interpolates from the current output value toward each new sample, one output sample per tick. It sits between the register interface (pcm, pcm_wr) and the channel-6 mixer, and replaces the fixed three-stage x8 resampler with a width- and depth-configurable core that adds stale-stream detection.

## Interface
- W, 9: signed sample width, 4..16.
- STAGES, 3: maximum up-rate exponent, 1..6; largest factor is 2^STAGES.
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  clock enable; every register below updates only when high.
- zero  in  1  output-sample strobe; each rising edge (sampled on clk_en cycles) is one tick.
- pcm  in  W  signed sample from register interface.
- pcm_wr  in  1  write strobe, one clk_en cycle per new sample.
- pcm_out  out  W  signed resampled output; reset 0.
- rate  out  $clog2(STAGES+1)  current exponent k; reset 0.
- stale  out  1  high while the write stream has stopped; reset 0.

## Operation
- Tick: tick = zero & ~last_zero, evaluated on clk_en cycles; last_zero updates on clk_en cycles.
- Gap counter: width STAGES+2; +1 per tick; saturates at GMAX = 2^(STAGES+1)-1; cleared by pcm_wr, with write taking priority over a same-cycle tick.
- Rate selection on pcm_wr: k = min(STAGES, floor(log2(gap))); gap 0 or 1 gives k=0, 2..3 gives 1, 4..7 gives 2, and so on. The value is registered into rate in the same cycle and applies to the segment that write starts.
- Segment start on pcm_wr: prev ← pcm_out, curr ← pcm, ph ← 0, stale ← 0.
- Per tick: ph ← min(ph+1, 2^k); pcm_out ← prev + (((curr − prev) · ph) >>> k).
  - Difference is W+1 bits signed.
  - Product is W+STAGES+2 bits signed.
  - Shift is arithmetic, so results round toward −∞.
  - Results always lie between prev and curr, so no overflow occurs.
- Write and tick in the same cycle: apply the segment start first, then the tick with ph=1. That gives pcm_out ← old pcm_out + (((pcm − old pcm_out)·1) >>> k_new).
- Late write (gap > 2^k): ph holds at 2^k and pcm_out holds at curr.
- Early write (ph < 2^k): the segment restarts from the current pcm_out. There is no jump in the output.
- Stale detection: when gap = GMAX and a tick arrives with no write, stale ← 1 (see Configuration).

## Timing
- Write to first output change: the next tick. With a same-cycle tick, the change appears in the same cycle's registered output.
- pcm_out is registered and changes only on tick cycles, plus decay ticks.
- rate and stale are registered and valid the cycle after the write or tick that sets them.
- rst_n low clears all state at once, including mid-segment, without waiting for clk. Operation resumes on the first clk_en cycle after release, with last_zero=0, so a zero that is already high counts as one tick.
- When clk_en is low, zero edges and pcm_wr are ignored entirely.

## Configuration
- JT12_PCM_DECAY_EN defined: while stale=1, each tick moves pcm_out one LSB toward 0 and holds it at 0. prev and curr are untouched, and the next write starts from the decayed pcm_out.
- JT12_PCM_DECAY_EN undefined: stale still asserts, and pcm_out holds its last value indefinitely.

## Test plan
- Reset: drive the stream to pcm_out=50, then pull rst_n low between clk edges. pcm_out, rate and stale must read 0 immediately.
- x1: writes every tick with pcm = 100, 101, 102. rate=0, and pcm_out follows with a 1-tick lag; with write and tick coincident, pcm_out is 100, 101, 102 in the same cycles.
- x8 (STAGES=3): steady writes every 8 ticks, sample 0 then 80. rate=3, and pcm_out steps 10, 20, … 80, then holds 80.
- Negative x4: writes every 4 ticks, 80 then −80. rate=2, and pcm_out steps 40, 0, −40, −80.
- Gating and early write: hold clk_en low across 3 zero edges, and gap is unchanged. A write at ph=2 of an x4 segment 0→80 (pcm_out=40) with pcm=0 must step from 40 downward with no discontinuity.
- Decay (W=9, STAGES=3): stop writes at pcm_out=5. After 15 ticks stale=1, then pcm_out goes 4, 3, 2, 1, 0, 0 with the macro defined, and holds 5 without it.
